// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings, slave state type and byte-lane helpers
package ahb_pkg;
  typedef enum logic [1:0] {TR_IDLE, TR_BUSY, TR_NONSEQ, TR_SEQ} htrans_t;
  typedef enum logic [2:0] {SZ_BYTE, SZ_HALF, SZ_WORD} hsize_t;
  typedef enum logic [2:0] {BU_SINGLE, BU_INCR, BU_WRAP4, BU_INCR4, BU_WRAP8, BU_INCR8, BU_WRAP16, BU_INCR16} hburst_t;
  typedef enum logic {RESP_OKAY, RESP_ERROR} hresp_t;
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} ahb_slv_state_t;
  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    return size == 2'd0 ? 32'h0000_00ff : size == 2'd1 ? 32'h0000_ffff : 32'hffff_ffff;
  endfunction
  function automatic logic [3:0] lane_we(input logic [1:0] size);
    return size == 2'd0 ? 4'b0001 : size == 2'd1 ? 4'b0011 : 4'b1111;
  endfunction
endpackage

// File: rtl/ahb_sram_bytes.sv
// ahb_sram_bytes: byte-addressed SRAM with four byte-lane write enables and a combinational 4-byte read
module ahb_sram_bytes #(
  parameter int MEM_BYTES = 512
) (
  input  logic                         HCLK,
  input  logic [3:0]                   we,
  input  logic [$clog2(MEM_BYTES)-1:0] addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);
  localparam int AW = $clog2(MEM_BYTES);
  logic [7:0] mem [MEM_BYTES];
  always_ff @(posedge HCLK)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr + AW'(i)] <= wdata[8*i +: 8];
  always_comb
    for (int i = 0; i < 4; i++) rdata[8*i +: 8] = mem[addr + AW'(i)];
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB slave terminating bus transfers into a byte-addressed on-chip SRAM
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int          MEM_BYTES   = 512,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRST_N,
  input  logic        HSEL_i,
  input  logic [31:0] HADDR_i,
  input  logic [1:0]  HTRANS_i,
  input  logic        HWRITE_i,
  input  logic [2:0]  HSIZE_i,
  input  logic [2:0]  HBURST_i,
  input  logic [31:0] HWDATA_i,
  input  logic        HREADY_i,
  output logic        HREADYOUT_o,
  output logic        HRESP_o,
  output logic [31:0] HRDATA_o
);
  localparam int AW = $clog2(MEM_BYTES);
  ahb_slv_state_t state, state_nx;
  logic [2:0] wcnt, wcnt_nx;
  logic [AW-1:0] off_q;
  logic [1:0] size_q;
  logic wr_q;
  logic [31:0] off, rdata;
  logic [32:0] off_end;
  logic accept, err, open;
  logic [3:0] we;
  logic unused_burst;
  assign unused_burst = ^HBURST_i;
  assign off = HADDR_i - BASE_ADDR;
  assign off_end = {1'b0, off} + (33'd1 << HSIZE_i);
  assign accept = HREADY_i && HSEL_i && (HTRANS_i == TR_NONSEQ || HTRANS_i == TR_SEQ);
  assign err = HADDR_i < BASE_ADDR || off_end > 33'(MEM_BYTES) || HSIZE_i > SZ_WORD ||
               (HSIZE_i == SZ_HALF && off[0]) || (HSIZE_i == SZ_WORD && off[1:0] != 2'b00);
  assign open = state == IDLE || state == DATA || state == ERR2;
  always_comb begin
    state_nx = state;
    wcnt_nx = wcnt;
    if (open && HREADY_i) begin
      state_nx = !accept ? IDLE : err ? ERR1 : WAIT_STATES > 0 ? WAIT : DATA;
      wcnt_nx = accept && !err && WAIT_STATES > 0 ? 3'(WAIT_STATES - 1) : 3'd0;
    end else if (state == WAIT) begin
      state_nx = wcnt == 3'd0 ? DATA : WAIT;
      wcnt_nx = wcnt == 3'd0 ? 3'd0 : wcnt - 3'd1;
    end else if (state == ERR1)
      state_nx = ERR2;
  end
  always_ff @(posedge HCLK or negedge HRST_N)
    if (!HRST_N) begin
      state <= IDLE;
      wcnt <= 3'd0;
      off_q <= '0;
      size_q <= 2'd0;
      wr_q <= 1'b0;
    end else begin
      state <= state_nx;
      wcnt <= wcnt_nx;
      if (open && accept) begin
        off_q <= off[AW-1:0];
        size_q <= HSIZE_i[1:0];
        wr_q <= HWRITE_i;
      end
    end
  assign we = state == DATA && wr_q ? lane_we(size_q) : 4'h0;
  assign HREADYOUT_o = !(state == WAIT || state == ERR1);
  assign HRESP_o = state == ERR1 || state == ERR2;
  assign HRDATA_o = state == DATA && !wr_q ? rdata & lane_mask(size_q) : 32'h0;
  ahb_sram_bytes #(.MEM_BYTES(MEM_BYTES)) u_mem (
    .HCLK(HCLK),
    .we(we),
    .addr(off_q),
    .wdata(HWDATA_i),
    .rdata(rdata)
  );
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB slave that terminates transfers from the SoC bus masters into a byte-addressed on-chip SRAM. Decodes NONSEQ/SEQ/BUSY/IDLE, supports byte/halfword/word accesses, configurable wait states, and the two-cycle ERROR response for out-of-range or misaligned accesses. Sits behind the bus decoder (HSEL) and is the target used to close the loop with the AHB master test driver.

## Interface
- MEM_BYTES, 512, SRAM size in bytes; power of two.
- BASE_ADDR, 32'h0000_0000, first byte address mapped to SRAM offset 0.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per valid transfer (0..7).
- HCLK  input  1  bus clock.
- HRST_N  input  1  reset; asynchronous, active-low.
- HSEL_i  input  1  slave select from decoder.
- HADDR_i  input  32  byte address.
- HTRANS_i  input  2  IDLE/BUSY/NONSEQ/SEQ.
- HWRITE_i  input  1  1 = write.
- HSIZE_i  input  3  0 byte, 1 halfword, 2 word; others → ERROR.
- HBURST_i  input  3  accepted, not used for addressing.
- HWDATA_i  input  32  write data, data phase.
- HREADY_i  input  1  bus-level HREADY (end of previous data phase).
- HREADYOUT_o  output  1  this slave's ready.
- HRESP_o  output  1  0 OKAY, 1 ERROR.
- HRDATA_o  output  32  read data.

## Operation
- Address phase accepted at rising edge when HREADY_i && HSEL_i && HTRANS_i ∈ {NONSEQ, SEQ}; captures offset = HADDR_i − BASE_ADDR, size, write.
- IDLE/BUSY, or HSEL_i low: no access; next data phase is zero-wait OKAY.
- Error check at capture: offset + (1<<size) > MEM_BYTES, HADDR_i below BASE_ADDR, offset not aligned to size, or HSIZE_i > 2.
- Data lanes: data is right-justified on bit 0 regardless of HADDR[1:0] (SoC convention). Byte: mem[off] ↔ [7:0]; halfword: mem[off+1:off] ↔ [15:0]; word: mem[off+3:off] ↔ [31:0], little-endian. Unused HRDATA bits read 0.
- FSM: IDLE → (valid accepted, WAIT_STATES>0) WAIT → DATA; IDLE → (valid, WAIT_STATES=0) DATA; IDLE → (error) ERR1 → ERR2 → IDLE/next.
- WAIT: HREADYOUT_o=0, counter decrements from WAIT_STATES−1; at 0 → DATA.
- DATA: HREADYOUT_o=1, HRESP_o=0; write commits HWDATA_i to memory at this edge; read drives HRDATA_o from memory. A new address phase may be accepted at the same edge (pipelined, back-to-back).
- ERR1: HREADYOUT_o=0, HRESP_o=1. ERR2: HREADYOUT_o=1, HRESP_o=1; write suppressed, HRDATA_o=0. A valid address phase at ERR2 end is accepted normally (master normally drives IDLE).
- Memory contents not reset.

## Timing
- Reset values: HREADYOUT_o=1, HRESP_o=0, HRDATA_o=0, FSM IDLE, wait counter 0.
- Latency: data phase is 1 + WAIT_STATES cycles after address phase for OKAY; ERROR always exactly 2 cycles, no wait states.
- HRDATA_o valid only in the cycle HREADYOUT_o=1 of a read DATA; 0 otherwise.
- Write followed immediately by read of same address: read returns new data (write commits at the edge the read address is captured).
- Reset mid-transfer: transfer abandoned, in-flight write not committed, outputs to reset values asynchronously.
- HREADY_i low (other slave stalling): no capture; state held.

## Structure
- Shared package ahb_pkg: HTRANS, HSIZE, HBURST, HRESP encodings and state enum ahb_slv_state_t {IDLE, WAIT, DATA, ERR1, ERR2}.
- Sub-module ahb_sram_bytes: MEM_BYTES×8 array, 4 byte write enables, combinational read of 4 bytes from an offset.

## Test plan
- WAIT_STATES=0, INCR4 word writes 0x11223344.. at 0x0..0xC, then INCR4 reads → identical data, HREADYOUT_o never low, HRESP_o=0.
- Byte write 0xAB to 0x5, halfword write 0xBEEF to 0x6, word read 0x4 → 0xBEEFAB_xx with byte 4 unchanged.
- WAIT_STATES=2, single word read → HREADYOUT_o low exactly 2 cycles, data on third data-phase cycle.
- Word read at offset 0x200 (MEM_BYTES=512) → ERR1 (READY 0, RESP 1) then ERR2 (READY 1, RESP 1); following access OKAY.
- Word write at 0x2 (misaligned) → 2-cycle ERROR, memory at 0x0..0x7 unchanged.
- INCR burst with BUSY inserted every 4 beats and HRST_N asserted during a WAIT → BUSY beats zero-wait OKAY with no access; reset returns HREADYOUT_o=1, aborted write absent.
